crc16_check_ctrl: RTL and testbench
===================================

Name: crc16_check_ctrl

Overview:
- Sequencer for the serial CRC-16 checker in the USB bulk-receive path.
- Sits between the bit-unstuffer/decoder and the crc_16_checker datapath:
  - clears the checker at start of a DATA payload;
  - gates shift_enable per valid received bit;
  - counts bits and bytes;
  - at EOP, compares the checker remainder against the USB CRC-16 residual and reports a one-cycle verdict to the packet FSM feeding the SD buffer.

Parameters:
- MAX_BYTES, 64, maximum payload bytes, excluding the 2 CRC bytes.
- CNT_W, 7, byte-counter width; must hold MAX_BYTES+3.
- RESIDUAL, 16'h800D, expected checker remainder after payload plus CRC bits.
- TIMEOUT_CYCLES, 255, idle cycles allowed between bits; used only with CRC_TIMEOUT_EN.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- sop  in  1  one-cycle pulse: payload starts, PID already stripped.
- eop  in  1  one-cycle pulse: end of packet.
- rx_bit_valid  in  1  decoded, unstuffed bit strobe.
- rx_bit  in  1  decoded bit, LSB-first order.
- crc_value  in  16  checker parallel_out.
- crc_clear  out  1  clears checker register to its init value.
- crc_shift_enable  out  1  to checker shift_enable.
- crc_serial_in  out  1  to checker serial_in.
- byte_count  out  CNT_W  completed bytes in current packet, CRC bytes included.
- busy  out  1  high in any state except IDLE.
- check_done  out  1  one-cycle verdict strobe.
- crc_ok  out  1  held pass flag.
- crc_err  out  1  held remainder-mismatch flag.
- align_err  out  1  held: EOP not on a byte boundary.
- len_err  out  1  held: fewer than 2 or more than MAX_BYTES+2 bytes.
- timeout_err  out  1  held; tied 0 without the macro.

Behaviour:
- Clock and reset: single clock clk. Reset rst is asynchronous and active-high. Reset forces:
  - state IDLE;
  - all outputs 0, byte_count 0;
  - bit counter (3-bit) 0.
- States: IDLE, CLEAR, SHIFT, SETTLE, CHECK.
- IDLE:
  - sop -> CLEAR.
  - eop and rx_bit_valid are ignored.
  - Held flags keep the last verdict.
- CLEAR, 1 cycle:
  - crc_clear=1.
  - Clear byte_count, bit counter and all held flags.
  - Go to SHIFT.
- SHIFT:
  - crc_shift_enable = rx_bit_valid and not len_err (combinational, same cycle).
  - crc_serial_in = rx_bit.
  - Each counted bit increments the bit counter. On wrap 7->0, byte_count increments.
  - If byte_count would exceed MAX_BYTES+2: set len_err, stop shifting, byte_count saturates, stay in SHIFT until eop.
  - eop -> SETTLE. An rx_bit_valid in the eop cycle is still shifted and counted.
- SETTLE, 1 cycle: checker register absorbs the last shift; crc_shift_enable=0.
- CHECK, 1 cycle:
  - check_done=1.
  - align_err = (bit counter != 0).
  - len_err |= (byte_count < 2).
  - crc_err = (crc_value != RESIDUAL).
  - crc_ok = no error flag set.
  - Flags register at the end of CHECK and stay held until the next CLEAR. Go to IDLE.
- Latency: eop to check_done is 2 cycles.
- sop in SHIFT, SETTLE or CHECK aborts the current packet and goes to CLEAR. No check_done is issued for the aborted packet.
- sop and eop in the same cycle in IDLE: sop wins, eop is ignored.
- Reset mid-packet returns immediately to IDLE and issues no verdict.

Optional Feature:
- Macro: CRC_TIMEOUT_EN.
- When defined:
  - An 8+ bit idle counter runs in SHIFT and resets on each rx_bit_valid.
  - On reaching TIMEOUT_CYCLES: set timeout_err, pulse check_done with crc_ok=0, go to IDLE.
- When undefined: no counter logic; timeout_err is constant 0; SHIFT waits indefinitely for eop.

Test Plan:
- Zero-length DATA packet:
  - sop, 16 zero bits (CRC 0x0000), eop.
  - Expect: check_done 2 cycles after eop, crc_ok=1, byte_count=2, all errors 0.
- Payload 0x03,0x02,0xA5,0xFE plus CRC from the bench golden model:
  - Expect crc_ok=1, byte_count=6.
  - Flip one payload bit: expect crc_err=1, crc_ok=0.
- Zero-length packet with 15 bits then eop:
  - Expect align_err=1, len_err=1, crc_ok=0.
- 67 bytes streamed with MAX_BYTES=64:
  - Expect len_err set at the 67th byte, crc_shift_enable low afterwards, byte_count=66.
- sop mid-packet after 20 bits:
  - Expect crc_clear pulse next cycle and no check_done for the first packet.
  - The second zero-length packet gives crc_ok=1.
- rst asserted mid-SHIFT: outputs 0 asynchronously.
- With CRC_TIMEOUT_EN:
  - 255 idle cycles in SHIFT: expect timeout_err=1 and a check_done pulse.
  - Without the macro: timeout_err stays 0.

Source files
------------

// File: rtl/crc16_check_ctrl_if.sv
// crc16_check_ctrl_if: decoder/checker-side bus of the USB CRC-16 check sequencer
interface crc16_check_ctrl_if #(parameter int CNT_W = 7);
  logic             sop;
  logic             eop;
  logic             rx_bit_valid;
  logic             rx_bit;
  logic [15:0]      crc_value;
  logic             crc_clear;
  logic             crc_shift_enable;
  logic             crc_serial_in;
  logic [CNT_W-1:0] byte_count;
  logic             busy;
  logic             check_done;
  logic             crc_ok;
  logic             crc_err;
  logic             align_err;
  logic             len_err;
  logic             timeout_err;
  modport master (
    output sop, eop, rx_bit_valid, rx_bit, crc_value,
    input  crc_clear, crc_shift_enable, crc_serial_in, byte_count, busy,
           check_done, crc_ok, crc_err, align_err, len_err, timeout_err
  );
  modport slave (
    input  sop, eop, rx_bit_valid, rx_bit, crc_value,
    output crc_clear, crc_shift_enable, crc_serial_in, byte_count, busy,
           check_done, crc_ok, crc_err, align_err, len_err, timeout_err
  );
endinterface

// File: rtl/crc16_check_ctrl.sv
// crc16_check_ctrl: sequences a serial USB CRC-16 checker over a DATA payload and reports a verdict.
// Optional inter-bit idle timeout enabled by defining CRC_TIMEOUT_EN.
module crc16_check_ctrl #(
  parameter int          MAX_BYTES      = 64,
  parameter int          CNT_W          = 7,
  parameter logic [15:0] RESIDUAL       = 16'h800D,
  parameter int          TIMEOUT_CYCLES = 255
) (
  input logic               clk,
  input logic               rst,
  crc16_check_ctrl_if.slave bus
);
  typedef enum logic [2:0] {IDLE, CLEAR, SHIFT, SETTLE, CHECK} state_t;
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_BYTES + 2);
  state_t     state;
  logic [2:0] bit_cnt;
  logic       shift;
  logic       timeout_hit;
  if (MAX_BYTES + 3 >= (1 << CNT_W) || TIMEOUT_CYCLES < 1) begin : g_bad_cfg
    $error("crc16_check_ctrl: CNT_W too narrow or TIMEOUT_CYCLES invalid");
  end
  assign shift = state == SHIFT && bus.rx_bit_valid && !bus.len_err;
  assign bus.crc_shift_enable = shift;
  assign bus.crc_serial_in = bus.rx_bit;
`ifdef CRC_TIMEOUT_EN
  localparam int IW = TIMEOUT_CYCLES > 255 ? $clog2(TIMEOUT_CYCLES + 1) : 8;
  logic [IW-1:0] idle_cnt;
  assign timeout_hit = state == SHIFT && !bus.rx_bit_valid && !bus.sop && !bus.eop &&
                       idle_cnt == IW'(TIMEOUT_CYCLES - 1);
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      idle_cnt        <= '0;
      bus.timeout_err <= 1'b0;
    end else begin
      idle_cnt        <= (state == SHIFT && !bus.rx_bit_valid) ? idle_cnt + 1'b1 : '0;
      bus.timeout_err <= bus.sop ? 1'b0 : timeout_hit ? 1'b1 : bus.timeout_err;
    end
`else
  assign timeout_hit = 1'b0;
  assign bus.timeout_err = 1'b0;
`endif
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state          <= IDLE;
      bit_cnt        <= '0;
      bus.byte_count <= '0;
      bus.busy       <= 1'b0;
      bus.crc_clear  <= 1'b0;
      bus.check_done <= 1'b0;
      bus.crc_ok     <= 1'b0;
      bus.crc_err    <= 1'b0;
      bus.align_err  <= 1'b0;
      bus.len_err    <= 1'b0;
    end else begin
      bus.crc_clear  <= 1'b0;
      bus.check_done <= 1'b0;
      bus.busy       <= 1'b1;
      if (bus.sop) begin
        // sop wins from any state; an aborted packet never reaches CHECK
        state          <= CLEAR;
        bus.crc_clear  <= 1'b1;
        bit_cnt        <= '0;
        bus.byte_count <= '0;
        bus.crc_ok     <= 1'b0;
        bus.crc_err    <= 1'b0;
        bus.align_err  <= 1'b0;
        bus.len_err    <= 1'b0;
      end else begin
        case (state)
          IDLE:    bus.busy <= 1'b0;
          CLEAR:   state <= SHIFT;
          SHIFT: begin
            if (shift) begin
              bit_cnt <= bit_cnt + 3'd1;
              if (bit_cnt == 3'd7) begin
                if (bus.byte_count == MAX_CNT) bus.len_err <= 1'b1;
                else bus.byte_count <= bus.byte_count + 1'b1;
              end
            end
            if (bus.eop) state <= SETTLE;
            else if (timeout_hit) begin
              state          <= IDLE;
              bus.check_done <= 1'b1;
              bus.busy       <= 1'b0;
            end
          end
          SETTLE: begin
            state          <= CHECK;
            bus.check_done <= 1'b1;
          end
          CHECK: begin
            state         <= IDLE;
            bus.busy      <= 1'b0;
            bus.align_err <= bit_cnt != 3'd0;
            bus.len_err   <= bus.len_err || bus.byte_count < CNT_W'(2);
            bus.crc_err   <= bus.crc_value != RESIDUAL;
            bus.crc_ok    <= bit_cnt == 3'd0 && !bus.len_err && bus.byte_count >= CNT_W'(2) &&
                             bus.crc_value == RESIDUAL;
          end
          default: state <= IDLE;
        endcase
      end
    end
endmodule

// File: tb/tb_crc16_check_ctrl.sv
// tb_crc16_check_ctrl: directed packets with a behavioural CRC-16 checker and a verdict scoreboard
module tb_crc16_check_ctrl;
  localparam int MAX_BYTES = 64;
  localparam int CNT_W = 7;
  typedef struct {bit ok; bit ce; bit ae; bit le; bit te; int bc; int due;} verdict_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  crc16_check_ctrl_if #(.CNT_W(CNT_W)) bus();
  crc16_check_ctrl #(.MAX_BYTES(MAX_BYTES), .CNT_W(CNT_W), .RESIDUAL(16'h800D), .TIMEOUT_CYCLES(255))
    dut (.clk(clk), .rst(rst), .bus(bus.slave));
  verdict_t exp_q[$];
  verdict_t cur;
  bit       stream[$];
  int       checks = 0, errors = 0, cyc = 0, done_cnt = 0, n_exp = 0;
  bit       pend = 0;
  logic [15:0] crc_reg = 16'hFFFF;
  function automatic logic [15:0] crc_step(input logic [15:0] q, input logic b);
    return {q[14:0], 1'b0} ^ ((b ^ q[15]) ? 16'h8005 : 16'h0000);
  endfunction
  function automatic logic [15:0] crc_of(input int n);
    logic [15:0] q;
    q = 16'hFFFF;
    for (int i = 0; i < n; i++) q = crc_step(q, stream[i]);
    return q;
  endfunction
  // checker datapath the controller drives
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (bus.crc_clear) crc_reg <= 16'hFFFF;
    else if (bus.crc_shift_enable) crc_reg <= crc_step(crc_reg, bus.crc_serial_in);
  end
  assign bus.crc_value = crc_reg;
  task automatic chk(input string n, input int a, input int e);
    checks++;
    if (a != e) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", n, a, e);
    end
  endtask
  always @(negedge clk) begin
    if (pend) begin
      pend = 0;
      chk("check_done_width", bus.check_done, 0);
      chk("crc_ok", bus.crc_ok, cur.ok);
      chk("crc_err", bus.crc_err, cur.ce);
      chk("align_err", bus.align_err, cur.ae);
      chk("len_err", bus.len_err, cur.le);
      chk("timeout_err", bus.timeout_err, cur.te);
      chk("byte_count", bus.byte_count, cur.bc);
    end
    if (bus.check_done) begin
      done_cnt++;
      if (exp_q.size() == 0) chk("unexpected_check_done", 1, 0);
      else begin
        cur = exp_q.pop_front();
        pend = 1;
        if (cur.due >= 0) chk("eop_to_check_done", cyc, cur.due);
      end
    end
  end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic add_byte(input logic [7:0] b);
    for (int i = 0; i < 8; i++) stream.push_back(b[i]);
  endtask
  task automatic add_crc();
    logic [15:0] q;
    q = crc_of(stream.size());
    for (int i = 15; i >= 0; i--) stream.push_back(~q[i]);
  endtask
  task automatic start_pkt();
    bus.sop = 1'b1;
    tick();
    bus.sop = 1'b0;
    @(negedge clk);
    chk("crc_clear", bus.crc_clear, 1);
    chk("busy", bus.busy, 1);
    chk("clear_byte_count", bus.byte_count, 0);
    tick();
  endtask
  task automatic send(input int from, input int to);
    for (int i = from; i < to; i++) begin
      bus.rx_bit_valid = 1'b1;
      bus.rx_bit = stream[i];
      tick();
    end
    bus.rx_bit_valid = 1'b0;
  endtask
  task automatic finish_pkt(input bit ok, input bit ce, input bit ae, input bit le, input int bc);
    verdict_t v;
    v.ok = ok; v.ce = ce; v.ae = ae; v.le = le; v.te = 1'b0; v.bc = bc; v.due = cyc + 2;
    exp_q.push_back(v);
    n_exp++;
    bus.eop = 1'b1;
    tick();
    bus.eop = 1'b0;
    bus.rx_bit_valid = 1'b0;
    repeat (4) tick();
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    bus.sop = 1'b0; bus.eop = 1'b0; bus.rx_bit_valid = 1'b0; bus.rx_bit = 1'b0;
    repeat (3) tick();
    @(negedge clk);
    chk("rst_busy", bus.busy, 0);
    chk("rst_byte_count", bus.byte_count, 0);
    chk("rst_check_done", bus.check_done, 0);
    chk("rst_crc_ok", bus.crc_ok, 0);
    chk("rst_len_err", bus.len_err, 0);
    chk("rst_crc_clear", bus.crc_clear, 0);
    rst = 1'b0;
    tick();
    // zero-length packet: CRC bytes 0x0000
    stream.delete(); add_crc();
    start_pkt(); send(0, 16); finish_pkt(1, 0, 0, 0, 2);
    // four-byte payload, last CRC bit arrives together with eop
    stream.delete(); add_byte(8'h03); add_byte(8'h02); add_byte(8'hA5); add_byte(8'hFE); add_crc();
    start_pkt(); send(0, 47);
    bus.rx_bit_valid = 1'b1; bus.rx_bit = stream[47];
    finish_pkt(1, 0, 0, 0, 6);
    // same packet with one payload bit flipped
    stream[3] = !stream[3];
    start_pkt(); send(0, 48); finish_pkt(0, 1, 0, 0, 6);
    // 15 bits only: misaligned and short
    stream.delete(); add_crc();
    start_pkt(); send(0, 15); finish_pkt(0, crc_of(15) != 16'h800D, 1, 1, 1);
    // oversize: 67 bytes against a 66-byte ceiling
    stream.delete();
    for (int i = 0; i < 67; i++) add_byte(8'(i + 1));
    start_pkt(); send(0, 528);
    @(negedge clk);
    chk("len_err_at_66", bus.len_err, 0);
    chk("byte_count_at_66", bus.byte_count, 66);
    send(528, 536);
    @(negedge clk);
    chk("len_err_at_67", bus.len_err, 1);
    chk("byte_count_sat", bus.byte_count, 66);
    bus.rx_bit_valid = 1'b1; bus.rx_bit = 1'b1;
    #1 chk("shift_en_after_len_err", bus.crc_shift_enable, 0);
    tick();
    bus.rx_bit_valid = 1'b0;
    finish_pkt(0, crc_of(536) != 16'h800D, 0, 1, 66);
    // abort after 20 bits, then a clean zero-length packet
    stream.delete(); add_byte(8'hA5); add_byte(8'h5A); add_byte(8'h3C);
    start_pkt(); send(0, 20);
    start_pkt();
    stream.delete(); add_crc();
    send(0, 16); finish_pkt(1, 0, 0, 0, 2);
    chk("no_verdict_for_abort", done_cnt, n_exp);
    // asynchronous reset in the middle of SHIFT
    stream.delete(); add_byte(8'hFF); add_byte(8'h00); add_byte(8'h81);
    start_pkt(); send(0, 20);
    bus.rx_bit_valid = 1'b1;
    #2 chk("shift_en_before_rst", bus.crc_shift_enable, 1);
    rst = 1'b1;
    #1;
    chk("async_rst_busy", bus.busy, 0);
    chk("async_rst_byte_count", bus.byte_count, 0);
    chk("async_rst_shift_en", bus.crc_shift_enable, 0);
    bus.rx_bit_valid = 1'b0;
    tick();
    rst = 1'b0;
    tick();
`ifdef CRC_TIMEOUT_EN
    begin
      verdict_t v;
      int k;
      stream.delete(); add_byte(8'h11);
      start_pkt(); send(0, 8);
      v.ok = 0; v.ce = 0; v.ae = 0; v.le = 0; v.te = 1; v.bc = 1; v.due = -1;
      exp_q.push_back(v);
      n_exp++;
      k = 0;
      while (done_cnt < n_exp && k < 400) begin
        tick();
        k++;
      end
      chk("timeout_verdict_seen", done_cnt, n_exp);
      repeat (3) tick();
    end
`else
    start_pkt();
    repeat (300) tick();
    chk("no_timeout_err", bus.timeout_err, 0);
    chk("still_busy", bus.busy, 1);
    chk("no_timeout_verdict", done_cnt, n_exp);
    stream.delete(); add_crc();
    send(0, 16); finish_pkt(1, 0, 0, 0, 2);
`endif
    repeat (3) tick();
    chk("scoreboard_empty", exp_q.size(), 0);
    chk("verdict_count", done_cnt, n_exp);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
